// File: rtl/alu_pipe_if.sv
// Bundle between the sub-action decoder, the action ALU and the PHV builder.
// The master side issues actions and consumes results; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48
);
  logic [ACTION_LEN-1:0] action_in;
  logic                  action_valid;
  logic                  action_ready;
  logic [DATA_WIDTH-1:0] operand_1_in;
  logic [DATA_WIDTH-1:0] operand_2_in;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] container_out;
  logic                  container_out_valid;
  logic                  container_out_flag;
  logic                  busy;

  modport master (
    output action_in, action_valid, operand_1_in, operand_2_in, out_ready,
    input  action_ready, container_out, container_out_valid, container_out_flag, busy
  );

  modport slave (
    input  action_in, action_valid, operand_1_in, operand_2_in, out_ready,
    output action_ready, container_out, container_out_valid, container_out_flag, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Fully pipelined action ALU: one op per cycle in, result LATENCY cycles later.
// A low out_ready freezes every stage, so nothing is dropped or duplicated.
module alu_pipe #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int LATENCY    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_pipe_if.slave bus
);
  localparam int W    = DATA_WIDTH;
  localparam int LAST = LATENCY - 1;

  localparam logic [3:0] OP_ADD     = 4'b0001;
  localparam logic [3:0] OP_ADD_ALT = 4'b1001;
  localparam logic [3:0] OP_SUB     = 4'b0010;
  localparam logic [3:0] OP_SUB_ALT = 4'b1010;
  localparam logic [3:0] OP_AND     = 4'b0011;
  localparam logic [3:0] OP_OR      = 4'b0100;
  localparam logic [3:0] OP_XOR     = 4'b0101;
  localparam logic [3:0] OP_SADD    = 4'b0110;
  localparam logic [3:0] OP_SSUB    = 4'b0111;
  localparam logic [3:0] OP_SHL     = 4'b1011;
  localparam logic [3:0] OP_SHR     = 4'b1100;
  localparam logic [3:0] OP_SET     = 4'b1110;

  logic [3:0]     opcode;
  logic           accept;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [6:0]     shamt;
  logic           sh_over;
  logic [2*W-1:0] shl;
  logic [2*W-1:0] shr;
  logic [W-1:0]   alu_data;
  logic           alu_flag;

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] flg;
  logic [W-1:0]       dat [LATENCY];

  logic unused_action;

  assign opcode        = bus.action_in[ACTION_LEN-1 -: 4];
  assign unused_action = ^bus.action_in[ACTION_LEN-5:0];
  assign op1           = bus.operand_1_in;
  assign op2           = bus.operand_2_in;

  // The whole pipeline advances in lockstep, so upstream readiness is downstream readiness.
  assign bus.action_ready = bus.out_ready;
  assign accept           = bus.action_valid & bus.out_ready;

  // One extra bit on add/sub exposes carry and borrow directly.
  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign diff = {1'b0, op1} - {1'b0, op2};

  // Double-width shifts keep the bits that fall off, which gives the flag for free.
  assign shamt   = op2[6:0];
  assign sh_over = {1'b0, shamt} >= 8'(W);
  assign shl     = {{W{1'b0}}, op1} << shamt;
  assign shr     = {op1, {W{1'b0}}} >> shamt;

  // NOTE: both outputs get a default before the case so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    alu_data = op1;
    alu_flag = 1'b0;
    case (opcode)
      OP_ADD, OP_ADD_ALT: begin
        alu_data = sum[W-1:0];
        alu_flag = sum[W];
      end
      OP_SUB, OP_SUB_ALT: begin
        alu_data = diff[W-1:0];
        alu_flag = diff[W];
      end
      OP_AND: alu_data = op1 & op2;
      OP_OR:  alu_data = op1 | op2;
      OP_XOR: alu_data = op1 ^ op2;
      OP_SADD: begin
        alu_data = sum[W] ? '1 : sum[W-1:0];
        alu_flag = sum[W];
      end
      OP_SSUB: begin
        alu_data = diff[W] ? '0 : diff[W-1:0];
        alu_flag = diff[W];
      end
      OP_SHL: begin
        alu_data = sh_over ? '0 : shl[W-1:0];
        alu_flag = sh_over ? |op1 : |shl[2*W-1:W];
      end
      OP_SHR: begin
        alu_data = sh_over ? '0 : shr[2*W-1:W];
        alu_flag = sh_over ? |op1 : |shr[W-1:0];
      end
      OP_SET: alu_data = op2;
      default: ;
    endcase
  end

  // Payloads only move behind a valid bit; bubbles leave the previous payload in place,
  // which is what keeps the outputs holding their last result between ops.
  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of the stage before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      flg <= '0;
      // NOTE: the payload array is reset too; the last entry is a visible output
      // that must read 0 out of reset, and the depth is small.
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else if (bus.out_ready) begin
      vld[0] <= accept;
      if (accept) begin
        dat[0] <= alu_data;
        flg[0] <= alu_flag;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
          flg[i] <= flg[i-1];
        end
      end
    end
  end

  assign bus.container_out       = dat[LAST];
  assign bus.container_out_flag  = flg[LAST];
  assign bus.container_out_valid = vld[LAST];
  // Derived purely from the stage valid flops, so it reflects the state after the edge.
  assign bus.busy                = |vld;
endmodule

// File: tb/tb_alu_pipe.sv
// Drives three alu_pipe instances (LATENCY 1, 2, 8) with the same stimulus and checks
// each one every cycle against a queue-based model of the accepted operations.
module tb_alu_pipe;
  localparam int AL = 25;
  localparam int W  = 48;
  localparam int NL = 3;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic [AL-1:0] action       = '0;
  logic          action_valid = 1'b0;
  logic [W-1:0]  op1          = '0;
  logic [W-1:0]  op2          = '0;
  logic          out_ready    = 1'b1;

  logic [W-1:0]  c_out [NL];
  logic [NL-1:0] c_valid;
  logic [NL-1:0] c_flag;
  logic [NL-1:0] c_busy;
  logic [NL-1:0] c_ready;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [W-1:0] d;
    logic         f;
    int           tag;
  } ent_t;

  ent_t          hist [$];
  int            head [NL] = '{default: 0};
  int            adv = 0;
  logic [NL-1:0] exp_valid = '0;
  logic [NL-1:0] exp_flag  = '0;
  logic [W-1:0]  exp_data [NL] = '{default: '0};

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 8;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    alu_pipe_if #(.ACTION_LEN(AL), .DATA_WIDTH(W)) bus ();
    assign bus.action_in    = action;
    assign bus.action_valid = action_valid;
    assign bus.operand_1_in = op1;
    assign bus.operand_2_in = op2;
    assign bus.out_ready    = out_ready;
    alu_pipe #(.STAGE_ID(g), .ACTION_LEN(AL), .DATA_WIDTH(W), .LATENCY(L)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
    assign c_out[g]   = bus.container_out;
    assign c_valid[g] = bus.container_out_valid;
    assign c_flag[g]  = bus.container_out_flag;
    assign c_busy[g]  = bus.busy;
    assign c_ready[g] = bus.action_ready;
  end

  // Reference ALU in plain 64-bit arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic f);
    longint unsigned ua, ub, lim;
    int n;
    ua  = 64'(a);
    ub  = 64'(b);
    lim = (64'd1 << W) - 64'd1;
    n   = int'(b[6:0]);
    r   = a;
    f   = 1'b0;
    case (op)
      4'd1, 4'd9:  begin r = W'(ua + ub); f = (ua + ub) > lim; end
      4'd2, 4'd10: begin r = W'(ua - ub); f = ua < ub; end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin f = (ua + ub) > lim; r = f ? W'(lim) : W'(ua + ub); end
      4'd7: begin f = ua < ub; r = f ? '0 : W'(ua - ub); end
      4'd11: begin
        if (n >= W) begin r = '0; f = ua != 0; end
        else begin r = W'(ua << n); f = (ua >> (W - n)) != 0; end
      end
      4'd12: begin
        if (n >= W) begin r = '0; f = ua != 0; end
        else begin r = W'(ua >> n); f = (ua & ((64'd1 << n) - 64'd1)) != 0; end
      end
      4'd14: r = b;
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d: got %h expected %h at %0t", name, lat_of(g), act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] er, input logic ef);
    logic [W-1:0] r;
    logic f;
    ref_op(op, a, b, r, f);
    check({name, "_data"}, 1, 64'(r), 64'(er));
    check({name, "_flag"}, 1, 64'(f), 64'(ef));
  endtask

  // Model: an op accepted on the a-th advancing edge sits at the output once
  // LATENCY-1 further advancing edges have passed, and stays there while stalled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      adv       = 0;
      exp_valid = '0;
      exp_flag  = '0;
      for (int g = 0; g < NL; g++) begin
        head[g]     = 0;
        exp_data[g] = '0;
      end
    end else if (out_ready) begin
      adv++;
      if (action_valid) begin
        logic [W-1:0] r;
        logic f;
        ref_op(action[AL-1 -: 4], op1, op2, r, f);
        hist.push_back('{d: r, f: f, tag: adv});
      end
      for (int g = 0; g < NL; g++) begin
        exp_valid[g] = 1'b0;
        if (head[g] < hist.size() && (adv - hist[head[g]].tag) == lat_of(g) - 1) begin
          exp_valid[g] = 1'b1;
          exp_data[g]  = hist[head[g]].d;
          exp_flag[g]  = hist[head[g]].f;
          head[g]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int g = 0; g < NL; g++) begin
        check("action_ready", g, 64'(c_ready[g]), 64'(out_ready));
        check("out_valid", g, 64'(c_valid[g]), 64'(exp_valid[g]));
        check("out_data", g, 64'(c_out[g]), 64'(exp_data[g]));
        check("out_flag", g, 64'(c_flag[g]), 64'(exp_flag[g]));
        check("busy", g, 64'(c_busy[g]), 64'((head[g] < hist.size()) || exp_valid[g]));
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rdy);
    action       = {op, 21'($urandom)};
    action_valid = v;
    op1          = a;
    op2          = b;
    out_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, '0, 1'b1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 70));
      default: return {16'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    #1 checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed expectations that pin the reference model.
    pin("add", 4'd1, 48'd5, 48'd7, 48'd12, 1'b0);
    pin("sub", 4'd2, 48'd3, 48'd5, 48'hFFFF_FFFF_FFFE, 1'b1);
    pin("sadd", 4'd6, 48'hFFFF_FFFF_FFF0, 48'h20, 48'hFFFF_FFFF_FFFF, 1'b1);
    pin("ssub", 4'd7, 48'd3, 48'd4, 48'd0, 1'b1);
    pin("shl", 4'd11, 48'h8000_0000_0001, 48'd1, 48'h2, 1'b1);
    pin("shr48", 4'd12, 48'h10, 48'd48, 48'd0, 1'b1);
    pin("shr_clean", 4'd12, 48'h10, 48'd4, 48'h1, 1'b0);
    pin("xor", 4'd5, 48'hF0F0, 48'h0FF0, 48'hFF00, 1'b0);
    pin("nop", 4'd15, 48'd9, 48'd1, 48'd9, 1'b0);

    // Single add through the LATENCY=2 instance, checked with literals as well.
    step(1'b1, 4'd1, 48'd5, 48'd7, 1'b1);
    step(1'b0, 4'd0, '0, '0, 1'b1);
    @(negedge clk);
    check("lit_add_out", 1, 64'(c_out[1]), 64'd12);
    check("lit_add_valid", 1, 64'(c_valid[1]), 64'd1);
    idle(10);

    // Back-to-back issue.
    step(1'b1, 4'd1, 48'd1, 48'd1, 1'b1);
    step(1'b1, 4'd2, 48'd3, 48'd5, 1'b1);
    step(1'b1, 4'd14, 48'd0, 48'hABC, 1'b1);
    step(1'b1, 4'd0, 48'd9, 48'd0, 1'b1);
    idle(10);

    // Saturation and shift edges.
    step(1'b1, 4'd6, 48'hFFFF_FFFF_FFF0, 48'h20, 1'b1);
    step(1'b1, 4'd7, 48'd3, 48'd4, 1'b1);
    step(1'b1, 4'd11, 48'h8000_0000_0001, 48'd1, 1'b1);
    step(1'b1, 4'd12, 48'h1234, 48'd48, 1'b1);
    step(1'b1, 4'd12, 48'd0, 48'd48, 1'b1);
    step(1'b1, 4'd11, 48'hFFFF_FFFF_FFFF, 48'd47, 1'b1);
    idle(10);

    // Stall with pending requests that must not be taken.
    step(1'b1, 4'd1, 48'd10, 48'd20, 1'b1);
    step(1'b1, 4'd2, 48'd100, 48'd1, 1'b1);
    step(1'b1, 4'd3, 48'hFF, 48'h0F, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd14, '0, 48'hDEAD, 1'b0);
    idle(12);

    // Reset with ops in flight.
    step(1'b1, 4'd1, 48'd40, 48'd2, 1'b1);
    step(1'b1, 4'd1, 48'd50, 48'd3, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12);

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if (i % 700 == 350) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 4'($urandom), rnd_operand(), rnd_operand(), $urandom_range(0, 4) != 0);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
